// File: rtl/word_slicer_param.sv
// word_slicer_param
//   Splits IN_W-bit words into RATIO = IN_W/OUT_W slices of OUT_W bits and
//   emits one slice per clk_4f cycle. Slice order is MSB-first or LSB-first.
//   Valid/ready handshakes on both sides. A one-word holding buffer lets the
//   next word be accepted while the current one is still being sliced, so
//   back-to-back words stream without bubbles.
//
// Ports
//   clk_4f     in   single clock, rising edge
//   reset      in   asynchronous, active-high reset
//   valid_in   in   Data_in holds a word
//   ready_in   out  a word can be accepted this cycle (holding buffer empty)
//   Data_in    in   [IN_W-1:0] input word
//   valid_out  out  Data_out holds a valid slice
//   ready_out  in   downstream takes the slice this cycle
//   Data_out   out  [OUT_W-1:0] current slice, 0 when idle
//   last_out   out  final slice of the current word
module word_slicer_param #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [IN_W-1:0]  Data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [OUT_W-1:0] Data_out,
  output logic             last_out
);

  localparam int RATIO = (OUT_W > 0) ? (IN_W / OUT_W) : 0;
  localparam int CNT_W = (RATIO < 2) ? 1 : $clog2(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  // Reject width combinations that cannot be sliced evenly into >= 2 pieces.
  if (OUT_W < 1 || (IN_W % OUT_W) != 0 || RATIO < 2) begin : g_param_check
    $error("word_slicer_param: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
  end

  logic [IN_W-1:0]  sr;
  logic [IN_W-1:0]  hb;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             hb_valid;

  logic             acc;
  logic             take;
  logic             fin;
  logic [OUT_W-1:0] slice;

  assign ready_in  = !hb_valid;
  assign valid_out = busy;
  assign last_out  = busy && (cnt == CNT_LAST);

  // The outgoing slice always sits at the end of SR that the shift moves
  // towards, so the slice select never depends on cnt.
  assign slice    = (MSB_FIRST != 0) ? sr[IN_W-1 -: OUT_W] : sr[OUT_W-1:0];
  assign Data_out = busy ? slice : '0;

  assign acc  = valid_in && ready_in;
  assign take = valid_out && ready_out;
  assign fin  = take && (cnt == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every update in
  // this block sees the pre-edge values of sr/cnt/busy/hb_valid.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      // NOTE: the data registers are cleared too, so nothing from an aborted
      // word can ever reappear on Data_out after reset is released.
      sr       <= '0;
      hb       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      hb_valid <= 1'b0;
    end else begin
      if (take && !fin) begin
        sr  <= (MSB_FIRST != 0) ? (sr << OUT_W) : (sr >> OUT_W);
        cnt <= cnt + 1'b1;
      end else if (fin) begin
        cnt <= '0;
        if (hb_valid) begin
          // Buffered word follows immediately; ready_in is low, so no acc.
          sr       <= hb;
          hb_valid <= 1'b0;
        end else if (acc) begin
          // Direct pass-through of a word arriving on the final slice.
          sr <= Data_in;
        end else begin
          busy <= 1'b0;
        end
      end else if (!busy && acc) begin
        sr   <= Data_in;
        busy <= 1'b1;
        cnt  <= '0;
      end

      // Word arriving mid-stream parks in the holding buffer; may coincide
      // with a shift above.
      if (busy && !fin && acc) begin
        hb       <= Data_in;
        hb_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_word_slicer_param.sv
// tb_word_slicer_param
//   Self-checking bench for word_slicer_param. Three instances: 32/8 MSB-first,
//   32/8 LSB-first and 16/4 MSB-first, sharing clock, reset and input
//   stimulus. A selector picks which instance's outputs are compared.
module tb_word_slicer_param;

  logic        clk_4f = 1'b0;
  logic        reset  = 1'b1;
  logic        valid_in  = 1'b0;
  logic [31:0] data_in   = '0;
  logic        ready_out = 1'b0;

  logic       m_rin, m_vout, m_last;
  logic [7:0] m_dout;
  logic       l_rin, l_vout, l_last;
  logic [7:0] l_dout;
  logic       s_rin, s_vout, s_last;
  logic [3:0] s_dout;

  int unsigned sel = 0;
  logic        obs_rin, obs_vout, obs_last;
  logic [31:0] obs_dout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_4f = ~clk_4f;

  word_slicer_param #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1)) dut_m (
    .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .ready_in(m_rin),
    .Data_in(data_in), .valid_out(m_vout), .ready_out(ready_out),
    .Data_out(m_dout), .last_out(m_last)
  );

  word_slicer_param #(.IN_W(32), .OUT_W(8), .MSB_FIRST(0)) dut_l (
    .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .ready_in(l_rin),
    .Data_in(data_in), .valid_out(l_vout), .ready_out(ready_out),
    .Data_out(l_dout), .last_out(l_last)
  );

  word_slicer_param #(.IN_W(16), .OUT_W(4), .MSB_FIRST(1)) dut_s (
    .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .ready_in(s_rin),
    .Data_in(data_in[15:0]), .valid_out(s_vout), .ready_out(ready_out),
    .Data_out(s_dout), .last_out(s_last)
  );

  always_comb begin
    obs_rin  = s_rin;
    obs_vout = s_vout;
    obs_last = s_last;
    obs_dout = {28'b0, s_dout};
    case (sel)
      0: begin
        obs_rin = m_rin; obs_vout = m_vout; obs_last = m_last; obs_dout = {24'b0, m_dout};
      end
      1: begin
        obs_rin = l_rin; obs_vout = l_vout; obs_last = l_last; obs_dout = {24'b0, l_dout};
      end
      default: ;
    endcase
  end

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [31:0] ed,
                            input logic el, input logic er);
    check({tag, ".valid_out"}, {31'b0, obs_vout}, {31'b0, ev});
    check({tag, ".Data_out"},  obs_dout,          ed);
    check({tag, ".last_out"},  {31'b0, obs_last}, {31'b0, el});
    check({tag, ".ready_in"},  {31'b0, obs_rin},  {31'b0, er});
  endtask

  // Apply inputs for one cycle, compare outputs at the falling edge, then
  // advance to just after the next rising edge.
  task automatic step(input string tag, input logic v, input logic [31:0] d, input logic r,
                      input logic ev, input logic [31:0] ed, input logic el, input logic er);
    valid_in  = v;
    data_in   = d;
    ready_out = r;
    @(negedge clk_4f);
    check_outs(tag, ev, ed, el, er);
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset();
    valid_in  = 1'b0;
    ready_out = 1'b0;
    @(negedge clk_4f);
    reset = 1'b1;
    repeat (2) @(posedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b0;
    @(posedge clk_4f);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r,
                              input logic ev, input logic [31:0] ed, input logic el,
                              input logic er);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.ev = ev; x.ed = ed; x.el = el; x.er = er;
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state while reset is held from time 0.
    #2;
    sel = 0;
    check_outs("reset_m", 1'b0, 32'h0, 1'b0, 1'b1);
    sel = 2;
    check_outs("reset_s", 1'b0, 32'h0, 1'b0, 1'b1);

    // ---- Table: MSB-first single word, back-to-back, backpressure,
    //      pass-through on the final slice.
    //        v     d             r     ev    ed      el    er
    // single word
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hDE, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hAD, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hBE, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hEF, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h00, 1'b0, 1'b1));
    // back-to-back: second word lands in HB, drains with no gap
    tbl.push_back(mk(1'b1, 32'h11223344, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 32'h55667788, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h22, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h33, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h44, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h55, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h66, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h77, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h88, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h00, 1'b0, 1'b1));
    // backpressure: AD stalled 3 cycles, one word accepted into HB,
    // a further offer ignored until HB drains
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hDE, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 32'h0BADF00D, 1'b0, 1'b1, 32'hAD, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 32'hAD, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h12345678, 1'b0, 1'b1, 32'hAD, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h12345678, 1'b1, 1'b1, 32'hAD, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h12345678, 1'b1, 1'b1, 32'hBE, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h12345678, 1'b1, 1'b1, 32'hEF, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 32'h12345678, 1'b1, 1'b1, 32'h0B, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hAD, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hF0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h0D, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h12, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h34, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h56, 1'b0, 1'b1));
    // word offered on the final slice with HB empty: direct pass-through
    tbl.push_back(mk(1'b1, 32'h9ABCDEF0, 1'b1, 1'b1, 32'h78, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h9A, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hBC, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hDE, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hF0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 32'h00, 1'b0, 1'b1));

    do_reset();
    sel = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].r,
           tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].er);
    end

    // ---- LSB-first order
    do_reset();
    sel = 1;
    step("lsb0", 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1);
    step("lsb1", 1'b0, 32'h0,        1'b1, 1'b1, 32'hEF, 1'b0, 1'b1);
    step("lsb2", 1'b0, 32'h0,        1'b1, 1'b1, 32'hBE, 1'b0, 1'b1);
    step("lsb3", 1'b0, 32'h0,        1'b1, 1'b1, 32'hAD, 1'b0, 1'b1);
    step("lsb4", 1'b0, 32'h0,        1'b1, 1'b1, 32'hDE, 1'b1, 1'b1);
    step("lsb5", 1'b0, 32'h0,        1'b1, 1'b0, 32'h00, 1'b0, 1'b1);

    // ---- Asynchronous reset mid-word, with a word parked in HB
    do_reset();
    sel = 0;
    step("rst0", 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1);
    step("rst1", 1'b1, 32'h11112222, 1'b1, 1'b1, 32'hDE, 1'b0, 1'b1);
    step("rst2", 1'b0, 32'h0,        1'b0, 1'b1, 32'hAD, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_outs("rst_async", 1'b0, 32'h00, 1'b0, 1'b1);
    @(posedge clk_4f);
    #1;
    check_outs("rst_hold", 1'b0, 32'h00, 1'b0, 1'b1);
    @(negedge clk_4f);
    reset = 1'b0;
    @(posedge clk_4f);
    #1;
    step("rst3", 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1);
    step("rst4", 1'b0, 32'h0,        1'b1, 1'b1, 32'hCA, 1'b0, 1'b1);
    step("rst5", 1'b0, 32'h0,        1'b1, 1'b1, 32'hFE, 1'b0, 1'b1);
    step("rst6", 1'b0, 32'h0,        1'b1, 1'b1, 32'hF0, 1'b0, 1'b1);
    step("rst7", 1'b0, 32'h0,        1'b1, 1'b1, 32'h0D, 1'b1, 1'b1);
    step("rst8", 1'b0, 32'h0,        1'b1, 1'b0, 32'h00, 1'b0, 1'b1);
    step("rst9", 1'b0, 32'h0,        1'b1, 1'b0, 32'h00, 1'b0, 1'b1);

    // ---- Alternate parameters: 16-bit words, 4-bit slices
    do_reset();
    sel = 2;
    step("n16_0", 1'b1, 32'h0000A5C3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step("n16_1", 1'b0, 32'h0,        1'b1, 1'b1, 32'hA, 1'b0, 1'b1);
    step("n16_2", 1'b0, 32'h0,        1'b1, 1'b1, 32'h5, 1'b0, 1'b1);
    step("n16_3", 1'b0, 32'h0,        1'b1, 1'b1, 32'hC, 1'b0, 1'b1);
    step("n16_4", 1'b0, 32'h0,        1'b1, 1'b1, 32'h3, 1'b1, 1'b1);
    step("n16_5", 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
